// File: rtl/rv32i_types_pkg.sv
// Shared RV32I decode types: opcode/funct constants, select encodings and the
// packed control bundle that travels down the decode pipeline.
package rv32i_types_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  // Operand A: register, PC (AUIPC/JAL) or zero (LUI)
  localparam logic [1:0] SEL_A_RS1  = 2'd0;
  localparam logic [1:0] SEL_A_PC   = 2'd1;
  localparam logic [1:0] SEL_A_ZERO = 2'd2;
  // Operand B: register or immediate
  localparam logic [1:0] SEL_B_RS2  = 2'd0;
  localparam logic [1:0] SEL_B_IMM  = 2'd1;
  // Writeback source
  localparam logic [1:0] W_SEL_ALU  = 2'd0;
  localparam logic [1:0] W_SEL_MEM  = 2'd1;
  localparam logic [1:0] W_SEL_PC4  = 2'd2;
  // Jump target: JAL (pc+imm) or JALR (rs1+imm)
  localparam logic       J_SEL_JAL  = 1'b0;
  localparam logic       J_SEL_JALR = 1'b1;

  // Encoded as {funct7[5], funct3} so legal R/I words map directly
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } aluop_t;

  // Encoded as the load funct3
  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } load_t;

  // Encoded as the branch funct3
  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } branch_t;

  typedef struct packed {
    logic        w_en;
    logic        dwen;
    logic        dren;
    logic        branch;
    logic        jump;
    logic        j_sel;
    logic        ex_pc_sel;
    logic [1:0]  alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic [1:0]  w_sel;
    aluop_t      alu_op;
    logic [3:0]  byte_en;
    load_t       load_type;
    branch_t     branch_type;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic        illegal;
    logic        is_system;
    logic        is_fence;
    logic        is_muldiv;
    logic [2:0]  muldiv_op;
  } ctrl_bundle_t;

endpackage

// File: rtl/rv32_decode_comb.sv
// Pure combinational RV32I(+M) decoder: instruction word and pc in, control
// bundle out. Illegal words still produce a bundle, with all enables cleared.
module rv32_decode_comb
  import rv32i_types_pkg::*;
#(
  parameter int RV32M_EN = 1
) (
  input  logic [31:0]  instr,
  input  logic [31:0]  pc,
  output ctrl_bundle_t ctrl
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] imm_shamt;
  logic [3:0]  mem_mask;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign imm_i     = {{20{instr[31]}}, instr[31:20]};
  assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u     = {instr[31:12], 12'b0};
  assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_shamt = {27'b0, instr[24:20]};
  assign mem_mask  = (funct3[1:0] == 2'b00) ? 4'b0001 :
                     (funct3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;

  // Decode by opcode, then mask enables for illegal words and rd == x0
  always_comb begin
    ctrl             = '0;
    ctrl.alu_op      = ALU_ADD;
    ctrl.load_type   = LD_B;
    ctrl.branch_type = BR_EQ;
    ctrl.rd          = instr[11:7];
    ctrl.rs1         = instr[19:15];
    ctrl.rs2         = instr[24:20];
    ctrl.pc          = pc;

    if (instr[1:0] != 2'b11) begin
      ctrl.illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI: begin
          ctrl.w_en      = 1'b1;
          ctrl.alu_a_sel = SEL_A_ZERO;
          ctrl.alu_b_sel = SEL_B_IMM;
          ctrl.imm       = imm_u;
        end
        OPC_AUIPC: begin
          ctrl.w_en      = 1'b1;
          ctrl.alu_a_sel = SEL_A_PC;
          ctrl.alu_b_sel = SEL_B_IMM;
          ctrl.imm       = imm_u;
        end
        OPC_JAL: begin
          ctrl.jump      = 1'b1;
          ctrl.j_sel     = J_SEL_JAL;
          ctrl.ex_pc_sel = 1'b1;
          ctrl.w_en      = 1'b1;
          ctrl.w_sel     = W_SEL_PC4;
          ctrl.alu_a_sel = SEL_A_PC;
          ctrl.alu_b_sel = SEL_B_IMM;
          ctrl.imm       = imm_j;
        end
        OPC_JALR: begin
          if (funct3 == 3'b000) begin
            ctrl.jump      = 1'b1;
            ctrl.j_sel     = J_SEL_JALR;
            ctrl.ex_pc_sel = 1'b1;
            ctrl.w_en      = 1'b1;
            ctrl.w_sel     = W_SEL_PC4;
            ctrl.alu_a_sel = SEL_A_RS1;
            ctrl.alu_b_sel = SEL_B_IMM;
            ctrl.imm       = imm_i;
          end else begin
            ctrl.illegal = 1'b1;
          end
        end
        OPC_BRANCH: begin
          if (funct3 == 3'b010 || funct3 == 3'b011) begin
            ctrl.illegal = 1'b1;
          end else begin
            ctrl.branch      = 1'b1;
            ctrl.ex_pc_sel   = 1'b1;
            ctrl.branch_type = branch_t'(funct3);
            ctrl.alu_op      = ALU_SUB;
            ctrl.alu_b_sel   = SEL_B_RS2;
            ctrl.imm         = imm_b;
          end
        end
        OPC_LOAD: begin
          case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: begin
              ctrl.dren      = 1'b1;
              ctrl.w_en      = 1'b1;
              ctrl.w_sel     = W_SEL_MEM;
              ctrl.alu_b_sel = SEL_B_IMM;
              ctrl.imm       = imm_i;
              ctrl.load_type = load_t'(funct3);
              ctrl.byte_en   = mem_mask;
            end
            default: ctrl.illegal = 1'b1;
          endcase
        end
        OPC_STORE: begin
          if (funct3[2] == 1'b0 && funct3[1:0] != 2'b11) begin
            ctrl.dwen      = 1'b1;
            ctrl.alu_b_sel = SEL_B_IMM;
            ctrl.imm       = imm_s;
            ctrl.byte_en   = mem_mask;
          end else begin
            ctrl.illegal = 1'b1;
          end
        end
        OPC_OP_IMM: begin
          ctrl.w_en      = 1'b1;
          ctrl.alu_b_sel = SEL_B_IMM;
          ctrl.imm       = imm_i;
          ctrl.alu_op    = aluop_t'({1'b0, funct3});
          if (funct3 == F3_SLL) begin
            ctrl.imm = imm_shamt;
            if (funct7 != FUNCT7_BASE) ctrl.illegal = 1'b1;
          end else if (funct3 == F3_SRL_SRA) begin
            ctrl.imm = imm_shamt;
            if (funct7 == FUNCT7_ALT) ctrl.alu_op = ALU_SRA;
            else if (funct7 != FUNCT7_BASE) ctrl.illegal = 1'b1;
          end
        end
        OPC_OP: begin
          if (funct7 == MULDIV_FUNCT7) begin
            if (RV32M_EN != 0) begin
              ctrl.is_muldiv = 1'b1;
              ctrl.muldiv_op = funct3;
              ctrl.w_en      = 1'b1;
              ctrl.alu_op    = ALU_ADD;
            end else begin
              ctrl.illegal = 1'b1;
            end
          end else if (funct7 == FUNCT7_BASE) begin
            ctrl.w_en   = 1'b1;
            ctrl.alu_op = aluop_t'({1'b0, funct3});
          end else if (funct7 == FUNCT7_ALT &&
                       (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)) begin
            ctrl.w_en   = 1'b1;
            ctrl.alu_op = aluop_t'({1'b1, funct3});
          end else begin
            ctrl.illegal = 1'b1;
          end
        end
        OPC_MISC_MEM: begin
          if (funct3 == 3'b000) ctrl.is_fence = 1'b1;
          else ctrl.illegal = 1'b1;
        end
        OPC_SYSTEM: begin
          if (instr == INSTR_ECALL || instr == INSTR_EBREAK) ctrl.is_system = 1'b1;
          else ctrl.illegal = 1'b1;
        end
        default: ctrl.illegal = 1'b1;
      endcase
    end

    if (ctrl.illegal) begin
      ctrl.w_en   = 1'b0;
      ctrl.dwen   = 1'b0;
      ctrl.dren   = 1'b0;
      ctrl.branch = 1'b0;
      ctrl.jump   = 1'b0;
    end
    if (ctrl.rd == 5'd0) ctrl.w_en = 1'b0;
  end

endmodule

// File: rtl/rv32_decode_pipe.sv
// Decode front end: combinational decoder feeding PIPE_DEPTH elastic register
// stages with valid/ready handshakes, flush, and a saturating stall counter.
module rv32_decode_pipe
  import rv32i_types_pkg::*;
#(
  parameter int PIPE_DEPTH = 2,
  parameter int RV32M_EN   = 1,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output ctrl_bundle_t     out_ctrl,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int LAST = PIPE_DEPTH - 1;

  ctrl_bundle_t            dec_ctrl;
  logic [PIPE_DEPTH-1:0]   v_q;
  logic [PIPE_DEPTH-1:0]   v_d;
  logic [PIPE_DEPTH-1:0]   adv;
  ctrl_bundle_t            data_q [PIPE_DEPTH];
  ctrl_bundle_t            data_d [PIPE_DEPTH];
  logic [CNT_W-1:0]        stall_cnt_q;
  logic [CNT_W-1:0]        stall_cnt_d;
  logic                    accept;

  rv32_decode_comb #(
    .RV32M_EN(RV32M_EN)
  ) u_decode (
    .instr(instr),
    .pc   (pc),
    .ctrl (dec_ctrl)
  );

  // A stage advances when it holds data and the stage after it has room
  always_comb begin
    adv       = '0;
    adv[LAST] = v_q[LAST] && out_ready;
    for (int i = LAST - 1; i >= 0; i--) begin
      adv[i] = v_q[i] && (!v_q[i+1] || adv[i+1]);
    end
  end

  assign in_ready  = !RST && !flush && (!v_q[0] || adv[0]);
  assign accept    = in_valid && in_ready;
  assign out_valid = v_q[LAST];
  assign out_ctrl  = data_q[LAST];
  assign stall_cnt = stall_cnt_q;

  // Shift bundles forward; flush drops all valids but leaves payloads untouched
  always_comb begin
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      v_d[i]    = v_q[i] && !adv[i];
      data_d[i] = data_q[i];
    end
    if (accept) begin
      v_d[0]    = 1'b1;
      data_d[0] = dec_ctrl;
    end
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      if (adv[i-1] && !flush) begin
        v_d[i]    = 1'b1;
        data_d[i] = data_q[i-1];
      end
    end
    if (flush) v_d = '0;
  end

  // Count cycles where the last stage is blocked, sticking at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Stage and counter registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      v_q         <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) data_q[i] <= '0;
    end else begin
      v_q         <= v_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < PIPE_DEPTH; i++) data_q[i] <= data_d[i];
    end
  end

endmodule

// File: tb/tb_rv32_decode_pipe.sv
// Directed bench for rv32_decode_pipe: three instances share one input stream
// (default build, RV32M disabled, 4-bit stall counter).
module tb_rv32_decode_pipe;
  import rv32i_types_pkg::*;

  logic         clk;
  logic         rst;
  logic         inValid;
  logic [31:0]  instrWord;
  logic [31:0]  pcValue;
  logic         flushReq;
  logic         outReady;

  logic         inReadyA, outValidA;
  ctrl_bundle_t outCtrlA;
  logic [15:0]  stallCntA;
  logic         inReadyM, outValidM;
  ctrl_bundle_t outCtrlM;
  logic [15:0]  stallCntM;
  logic         inReadyC, outValidC;
  ctrl_bundle_t outCtrlC;
  logic [3:0]   stallCntC;

  int checks;
  int failures;

  rv32_decode_pipe #(.PIPE_DEPTH(2), .RV32M_EN(1), .CNT_W(16)) dutA (
    .CLK(clk), .RST(rst), .in_valid(inValid), .in_ready(inReadyA),
    .instr(instrWord), .pc(pcValue), .flush(flushReq), .out_valid(outValidA),
    .out_ready(outReady), .out_ctrl(outCtrlA), .stall_cnt(stallCntA)
  );

  rv32_decode_pipe #(.PIPE_DEPTH(2), .RV32M_EN(0), .CNT_W(16)) dutM (
    .CLK(clk), .RST(rst), .in_valid(inValid), .in_ready(inReadyM),
    .instr(instrWord), .pc(pcValue), .flush(flushReq), .out_valid(outValidM),
    .out_ready(outReady), .out_ctrl(outCtrlM), .stall_cnt(stallCntM)
  );

  rv32_decode_pipe #(.PIPE_DEPTH(2), .RV32M_EN(1), .CNT_W(4)) dutC (
    .CLK(clk), .RST(rst), .in_valid(inValid), .in_ready(inReadyC),
    .instr(instrWord), .pc(pcValue), .flush(flushReq), .out_valid(outValidC),
    .out_ready(outReady), .out_ctrl(outCtrlC), .stall_cnt(stallCntC)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence never completes
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic [31:0] p,
                               input logic fl, input logic ordy, input logic rs);
    inValid   = v;
    instrWord = w;
    pcValue   = p;
    flushReq  = fl;
    outReady  = ordy;
    rst       = rs;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one word for a cycle, then idle one cycle so it reaches the last stage
  task automatic sendWord(input logic [31:0] w, input logic [31:0] p, input logic ordy);
    applyStimulus(1'b1, w, p, 1'b0, ordy, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, ordy, 1'b0);
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1; inValid = 1'b0; instrWord = '0; pcValue = '0; flushReq = 1'b0; outReady = 1'b1;
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("reset_in_ready", inReadyA, 0);
    checkOutput("reset_out_valid", outValidA, 0);
    checkOutput("reset_out_ctrl", outCtrlA, 0);
    checkOutput("reset_stall_cnt", stallCntA, 0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("idle_in_ready", inReadyA, 1);

    $display("[TB] streaming ADDI then SW");
    applyStimulus(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("stream_latency", outValidA, 0);
    applyStimulus(1'b1, 32'h0011_2223, 32'h104, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("addi_valid", outValidA, 1);
    checkOutput("addi_w_en", outCtrlA.w_en, 1);
    checkOutput("addi_rd", outCtrlA.rd, 1);
    checkOutput("addi_imm", outCtrlA.imm, 5);
    checkOutput("addi_pc", outCtrlA.pc, 32'h100);
    tick();
    checkOutput("sw_valid", outValidA, 1);
    checkOutput("sw_dwen", outCtrlA.dwen, 1);
    checkOutput("sw_byte_en", outCtrlA.byte_en, 4'hF);
    checkOutput("sw_imm", outCtrlA.imm, 4);
    checkOutput("sw_w_en", outCtrlA.w_en, 0);
    checkOutput("sw_rs1", outCtrlA.rs1, 2);
    checkOutput("sw_rs2", outCtrlA.rs2, 1);
    tick();
    checkOutput("stream_drain", outValidA, 0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'h0010_0093, 32'h110, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_accept_a", inReadyA, 1);
    tick();
    applyStimulus(1'b1, 32'h0020_0113, 32'h114, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_accept_b", inReadyA, 1);
    tick();
    applyStimulus(1'b1, 32'h0030_0193, 32'h118, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_in_ready", inReadyA, 0);
      checkOutput("bp_hold_imm", outCtrlA.imm, 1);
      checkOutput("bp_hold_pc", outCtrlA.pc, 32'h110);
      tick();
    end
    checkOutput("bp_stall_cnt", stallCntA, 5);
    applyStimulus(1'b1, 32'h0030_0193, 32'h118, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_release_ready", inReadyA, 1);
    checkOutput("bp_out0_imm", outCtrlA.imm, 1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("bp_out1_valid", outValidA, 1);
    checkOutput("bp_out1_imm", outCtrlA.imm, 2);
    tick();
    checkOutput("bp_out2_valid", outValidA, 1);
    checkOutput("bp_out2_imm", outCtrlA.imm, 3);
    tick();
    checkOutput("bp_empty", outValidA, 0);
    checkOutput("bp_stall_final", stallCntA, 5);

    $display("[TB] flush");
    applyStimulus(1'b1, 32'h0040_0213, 32'h120, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0050_0293, 32'h124, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0060_0313, 32'h128, 1'b1, 1'b1, 1'b0);
    checkOutput("flush_pre_valid", outValidA, 1);
    checkOutput("flush_in_ready", inReadyA, 0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_out_valid", outValidA, 0);
    checkOutput("flush_ready_after", inReadyA, 1);
    checkOutput("flush_payload_kept", outCtrlA.imm, 4);
    tick();
    checkOutput("flush_nothing_out", outValidA, 0);

    $display("[TB] decode cases");
    sendWord(32'h0220_81B3, 32'h200, 1'b1);
    checkOutput("mul_valid", outValidA, 1);
    checkOutput("mul_is_muldiv", outCtrlA.is_muldiv, 1);
    checkOutput("mul_op", outCtrlA.muldiv_op, 0);
    checkOutput("mul_illegal", outCtrlA.illegal, 0);
    checkOutput("mul_w_en", outCtrlA.w_en, 1);
    checkOutput("mul_rd", outCtrlA.rd, 3);
    checkOutput("mul_nom_valid", outValidM, 1);
    checkOutput("mul_nom_illegal", outCtrlM.illegal, 1);
    checkOutput("mul_nom_w_en", outCtrlM.w_en, 0);
    checkOutput("mul_nom_muldiv", outCtrlM.is_muldiv, 0);

    sendWord(32'h0000_0000, 32'h204, 1'b1);
    checkOutput("zero_valid", outValidA, 1);
    checkOutput("zero_illegal", outCtrlA.illegal, 1);
    checkOutput("zero_enables",
                {outCtrlA.w_en, outCtrlA.dwen, outCtrlA.dren, outCtrlA.branch, outCtrlA.jump}, 0);

    sendWord(32'hFE00_0EE3, 32'h208, 1'b1);
    checkOutput("beq_branch", outCtrlA.branch, 1);
    checkOutput("beq_imm", outCtrlA.imm, 32'hFFFF_FFFC);
    checkOutput("beq_illegal", outCtrlA.illegal, 0);
    checkOutput("beq_type", outCtrlA.branch_type, BR_EQ);
    checkOutput("beq_w_en", outCtrlA.w_en, 0);

    sendWord(32'h0080_A283, 32'h20C, 1'b1);
    checkOutput("lw_dren", outCtrlA.dren, 1);
    checkOutput("lw_byte_en", outCtrlA.byte_en, 4'hF);
    checkOutput("lw_load_type", outCtrlA.load_type, LD_W);
    checkOutput("lw_imm", outCtrlA.imm, 8);
    checkOutput("lw_w_en", outCtrlA.w_en, 1);

    sendWord(32'h4020_D093, 32'h210, 1'b1);
    checkOutput("srai_illegal", outCtrlA.illegal, 0);
    checkOutput("srai_alu_op", outCtrlA.alu_op, ALU_SRA);
    checkOutput("srai_imm", outCtrlA.imm, 2);

    sendWord(32'h4220_D093, 32'h214, 1'b1);
    checkOutput("srai_b25_illegal", outCtrlA.illegal, 1);
    checkOutput("srai_b25_w_en", outCtrlA.w_en, 0);
    tick();
    checkOutput("decode_drain", outValidA, 0);

    $display("[TB] stall counter saturation");
    sendWord(32'h0010_0093, 32'h300, 1'b0);
    checkOutput("sat_valid", outValidA, 1);
    checkOutput("sat_start_cnt", stallCntC, 5);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 9) checkOutput("sat_cnt_14", stallCntC, 14);
      if (i == 10) checkOutput("sat_cnt_15", stallCntC, 15);
    end
    checkOutput("sat_cnt_held", stallCntC, 15);
    checkOutput("sat_wide_cnt", stallCntA, 25);
    checkOutput("sat_hold_imm", outCtrlA.imm, 1);

    $display("[TB] reset mid-stall");
    applyStimulus(1'b1, 32'h0050_0093, 32'h400, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_in_ready", inReadyA, 0);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_out_valid", outValidA, 0);
    checkOutput("rst_out_ctrl", outCtrlA, 0);
    checkOutput("rst_stall_cnt", stallCntA, 0);
    checkOutput("rst_stall_cnt_c", stallCntC, 0);
    checkOutput("rst_ready_after", inReadyA, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
